// File: rtl/external_interrupt_controller_pkg.sv
// Shared constants and FSM encoding for the external interrupt controller.
// Optional feature: EIC_INTMASK_EN adds the per-source Src_IntMask port to the top.
package external_interrupt_controller_pkg;

   localparam int unsigned NUM_SRC = 2;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      REQ   = 2'd2,
      HOLD  = 2'd3
   } eic_state_t;

   // Lowest-numbered set bit wins, so source 0 has priority.
   function automatic logic first_set(input logic [NUM_SRC-1:0] v);
      first_set = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            first_set = i[0];
         end
      end
   endfunction

endpackage

// File: rtl/external_interrupt_controller_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the Sys_Clock domain.
module external_interrupt_controller_synchronizer #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/external_interrupt_controller.sv
// Edge-latched interrupt sources serviced one at a time over a toggle-ack handshake.
// Define EIC_INTMASK_EN to add Src_IntMask gating which pending bits are eligible.
module external_interrupt_controller
   import external_interrupt_controller_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES = 2,
   parameter int unsigned GAP_CYCLES   = 3
) (
   input  logic               Sys_Clock,
   input  logic               Sys_Reset,
   input  logic [NUM_SRC-1:0] Src_IntReq,
`ifdef EIC_INTMASK_EN
   input  logic [NUM_SRC-1:0] Src_IntMask,
`endif
   input  logic               EIC_IntAck,
   output logic               EIC_IntReq,
   output logic               EIC_IntId,
   output logic [NUM_SRC-1:0] Eic_Pending,
   output logic               Eic_Busy
);

   localparam int unsigned CNT_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   eic_state_t         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_req;
   logic               r_id;
   logic [NUM_SRC-1:0] r_src_prev;
   logic [NUM_SRC-1:0] r_pending;
   logic               r_ack_prev;

   logic               w_ack_sync;
   logic               w_ack;
   logic [NUM_SRC-1:0] w_set;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_eligible;

   external_interrupt_controller_synchronizer #(
      .STAGES (2)
   ) u_ack_sync (
      .i_clk   (Sys_Clock),
      .i_rst_n (Sys_Reset),
      .i_d     (EIC_IntAck),
      .o_q     (w_ack_sync)
   );

   // Any change of the synchronized level is one acknowledge.
   assign w_ack = w_ack_sync ^ r_ack_prev;
   assign w_set = Src_IntReq & ~r_src_prev;
   assign w_clr = (r_state == REQ && w_ack) ? (NUM_SRC'(1) << r_id) : '0;

`ifdef EIC_INTMASK_EN
   assign w_eligible = r_pending & Src_IntMask;
`else
   assign w_eligible = r_pending;
`endif

   always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
      if (!Sys_Reset) begin
         r_src_prev <= '0;
         r_pending  <= '0;
         r_ack_prev <= FALSE;
      end else begin
         r_src_prev <= Src_IntReq;
         // A new edge on the bit being cleared keeps it pending.
         r_pending  <= (r_pending & ~w_clr) | w_set;
         r_ack_prev <= w_ack_sync;
      end
   end

   always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
      if (!Sys_Reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_req   <= FALSE;
         r_id    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_eligible) begin
                  r_state <= SETUP;
                  r_id    <= first_set(w_eligible);
                  r_cnt   <= '0;
               end
            end
            SETUP: begin
               if (r_cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                  r_state <= REQ;
                  r_req   <= TRUE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            REQ: begin
               if (w_ack) begin
                  r_state <= HOLD;
                  r_req   <= FALSE;
                  r_cnt   <= '0;
               end
            end
            HOLD: begin
               if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= FALSE;
            end
         endcase
      end
   end

   assign EIC_IntReq  = r_req;
   assign EIC_IntId   = r_id;
   assign Eic_Pending = r_pending;
   assign Eic_Busy    = (r_state != IDLE);

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Directed bench for external_interrupt_controller; a monitor scores each request rise
// against a queue of expected IDs filled by the stimulus thread.
module tb_external_interrupt_controller;
   import external_interrupt_controller_pkg::*;

   logic       Sys_Clock  = 1'b0;
   logic       Sys_Reset  = 1'b1;
   logic       EIC_IntAck = 1'b0;
   logic [1:0] Src_IntReq = 2'b00;
`ifdef EIC_INTMASK_EN
   logic [1:0] Src_IntMask = 2'b11;
`endif
   logic       EIC_IntReq;
   logic       EIC_IntId;
   logic [1:0] Eic_Pending;
   logic       Eic_Busy;

   int   checks = 0;
   int   errors = 0;
   int   rises  = 0;
   logic exp_q[$];
   logic mon_prev = 1'b0;
   logic mon_d1   = 1'b0;
   logic mon_d2   = 1'b0;
   logic mon_exp;
   int   n;

   external_interrupt_controller #(
      .SETUP_CYCLES (2),
      .GAP_CYCLES   (3)
   ) dut (
      .Sys_Clock   (Sys_Clock),
      .Sys_Reset   (Sys_Reset),
      .Src_IntReq  (Src_IntReq),
`ifdef EIC_INTMASK_EN
      .Src_IntMask (Src_IntMask),
`endif
      .EIC_IntAck  (EIC_IntAck),
      .EIC_IntReq  (EIC_IntReq),
      .EIC_IntId   (EIC_IntId),
      .Eic_Pending (Eic_Pending),
      .Eic_Busy    (Eic_Busy)
   );

   initial begin
      forever #5 Sys_Clock = ~Sys_Clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Sys_Clock);
      #1;
   endtask

   task automatic pulse(input logic [1:0] m);
      Src_IntReq = m;
      tick();
      Src_IntReq = 2'b00;
   endtask

   task automatic wait_req(input logic lvl, input int budget, input string name);
      int k;
      k = 0;
      while (EIC_IntReq !== lvl && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(EIC_IntReq), 32'(lvl));
   endtask

   // Toggle arrives mid-cycle: two edges to synchronize, the third drops the request.
   task automatic ack_cycle(input string name);
      EIC_IntAck = ~EIC_IntAck;
      tick();
      tick();
      check({name, "_held"}, 32'(EIC_IntReq), 32'd1);
      tick();
      check({name, "_fall"}, 32'(EIC_IntReq), 32'd0);
   endtask

   initial begin
      forever begin
         @(posedge Sys_Clock);
         #1;
         if (EIC_IntReq === 1'b1 && mon_prev !== 1'b1) begin
            rises++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got id %0d, required no request", EIC_IntId);
            end else begin
               mon_exp = exp_q.pop_front();
               check("req_id", 32'(EIC_IntId), 32'(mon_exp));
               check("id_two_cycles_early", 32'(mon_d2), 32'(mon_exp));
            end
         end
         mon_prev = EIC_IntReq;
         mon_d2   = mon_d1;
         mon_d1   = EIC_IntId;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      #2 Sys_Reset = 1'b0;
      #1;
      check("rst_req", 32'(EIC_IntReq), 32'd0);
      check("rst_id", 32'(EIC_IntId), 32'd0);
      check("rst_pend", 32'(Eic_Pending), 32'd0);
      check("rst_busy", 32'(Eic_Busy), 32'd0);
      tick();
      tick();
      Sys_Reset = 1'b1;
      tick();

      // Single source 1 request with exact latencies
      exp_q.push_back(1'b1);
      pulse(2'b10);
      check("t1_pend", 32'(Eic_Pending), 32'b10);
      check("t1_busy_idle", 32'(Eic_Busy), 32'd0);
      tick();
      check("t1_setup_busy", 32'(Eic_Busy), 32'd1);
      check("t1_setup_id", 32'(EIC_IntId), 32'd1);
      check("t1_setup_req0", 32'(EIC_IntReq), 32'd0);
      tick();
      check("t1_setup_req1", 32'(EIC_IntReq), 32'd0);
      tick();
      check("t1_req_rise", 32'(EIC_IntReq), 32'd1);
      repeat (10) tick();
      check("t1_req_no_timeout", 32'(EIC_IntReq), 32'd1);
      ack_cycle("t1");
      check("t1_pend_clr", 32'(Eic_Pending), 32'd0);
      check("t1_hold_busy", 32'(Eic_Busy), 32'd1);
      tick();
      tick();
      check("t1_gap_busy", 32'(Eic_Busy), 32'd1);
      tick();
      check("t1_idle", 32'(Eic_Busy), 32'd0);

      // Simultaneous edges: source 0 first, source 1 after the gap
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      pulse(2'b11);
      check("t2_pend", 32'(Eic_Pending), 32'b11);
      wait_req(1'b1, 10, "t2_req0");
      ack_cycle("t2a");
      check("t2_pend_after0", 32'(Eic_Pending), 32'b10);
      n = 0;
      while (EIC_IntReq !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("t2_fall_to_rise", 32'(n), 32'd6);
      ack_cycle("t2b");
      check("t2_pend_clr", 32'(Eic_Pending), 32'd0);
      repeat (3) tick();
      check("t2_idle", 32'(Eic_Busy), 32'd0);
      check("t2_rises", 32'(rises), 32'd3);

      // Source 0 edge on the clearing edge keeps it pending; second ID 0 request follows
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      pulse(2'b01);
      wait_req(1'b1, 10, "t3_req");
      EIC_IntAck = ~EIC_IntAck;
      tick();
      tick();
      check("t3_held", 32'(EIC_IntReq), 32'd1);
      Src_IntReq = 2'b01;
      tick();
      Src_IntReq = 2'b00;
      check("t3_fall", 32'(EIC_IntReq), 32'd0);
      check("t3_set_wins", 32'(Eic_Pending), 32'b01);
      wait_req(1'b1, 20, "t3_second_req");
      ack_cycle("t3b");
      check("t3_pend_clr", 32'(Eic_Pending), 32'd0);
      repeat (3) tick();
      check("t3_idle", 32'(Eic_Busy), 32'd0);

      // Stray ack while idle is ignored
      EIC_IntAck = ~EIC_IntAck;
      repeat (5) tick();
      check("t4_busy", 32'(Eic_Busy), 32'd0);
      check("t4_pend", 32'(Eic_Pending), 32'd0);
      check("t4_req", 32'(EIC_IntReq), 32'd0);
      exp_q.push_back(1'b1);
      pulse(2'b10);
      wait_req(1'b1, 10, "t4_req_rise");
      ack_cycle("t4");
      repeat (3) tick();
      check("t4_idle", 32'(Eic_Busy), 32'd0);

      // Asynchronous reset while requesting
      exp_q.push_back(1'b0);
      pulse(2'b01);
      wait_req(1'b1, 10, "t5_req");
      pulse(2'b10);
      check("t5_pend_before", 32'(Eic_Pending), 32'b11);
      #2;
      Sys_Reset  = 1'b0;
      EIC_IntAck = 1'b0;
      #1;
      check("t5_rst_req", 32'(EIC_IntReq), 32'd0);
      check("t5_rst_pend", 32'(Eic_Pending), 32'd0);
      check("t5_rst_busy", 32'(Eic_Busy), 32'd0);
      check("t5_rst_id", 32'(EIC_IntId), 32'd0);
      @(negedge Sys_Clock);
      Sys_Reset = 1'b1;
      tick();
      tick();
      check("t5_stays_idle", 32'(Eic_Busy), 32'd0);

`ifdef EIC_INTMASK_EN
      // Masked source latches but is not serviced until unmasked
      Src_IntMask = 2'b10;
      pulse(2'b01);
      check("t6_pend", 32'(Eic_Pending), 32'b01);
      repeat (4) tick();
      check("t6_masked_busy", 32'(Eic_Busy), 32'd0);
      check("t6_masked_req", 32'(EIC_IntReq), 32'd0);
      exp_q.push_back(1'b0);
      Src_IntMask = 2'b11;
      tick();
      check("t6_setup", 32'(Eic_Busy), 32'd1);
      wait_req(1'b1, 10, "t6_req");
      ack_cycle("t6");
      repeat (3) tick();
      check("t6_idle", 32'(Eic_Busy), 32'd0);
`endif

      repeat (3) tick();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
